// File: rtl/cordic_vectoring_if.sv
// Handshake and data bundle for the vectoring CORDIC: input vector (x, y) on one
// side, magnitude/angle result on the other, each with its own valid/ready pair.
`timescale 1ns/1ps

interface cordic_vectoring_if;
    logic               valid_i;
    logic               ready_o;
    logic signed [16:0] x_i;
    logic signed [16:0] y_i;
    logic               valid_o;
    logic               ready_i;
    logic        [17:0] mag_o;
    logic signed [17:0] angle_o;

    // The block itself is the slave; whoever feeds vectors and drains results is the master.
    modport slave (
        input  valid_i, x_i, y_i, ready_i,
        output ready_o, valid_o, mag_o, angle_o
    );

    modport master (
        output valid_i, x_i, y_i, ready_i,
        input  ready_o, valid_o, mag_o, angle_o
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative 16-step vectoring CORDIC: (x, y) -> (magnitude, atan2 angle in rad * 2^15).
// Define CORDIC_VEC_GAIN_COMP_EN to add a one-cycle COMP state that removes the CORDIC gain.
`timescale 1ns/1ps

module cordic_vectoring (
    input  logic                clk_i,
    input  logic                reset_ni,
    cordic_vectoring_if.slave   vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
`ifdef CORDIC_VEC_GAIN_COMP_EN
        COMP = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    localparam logic signed [17:0] Z_HALF_PI = 18'sd51472;

    function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 18'sd25735;
            4'd1:    atan_lut = 18'sd15192;
            4'd2:    atan_lut = 18'sd8027;
            4'd3:    atan_lut = 18'sd4075;
            4'd4:    atan_lut = 18'sd2045;
            4'd5:    atan_lut = 18'sd1024;
            4'd6:    atan_lut = 18'sd512;
            4'd7:    atan_lut = 18'sd256;
            4'd8:    atan_lut = 18'sd128;
            4'd9:    atan_lut = 18'sd64;
            4'd10:   atan_lut = 18'sd32;
            4'd11:   atan_lut = 18'sd16;
            4'd12:   atan_lut = 18'sd8;
            4'd13:   atan_lut = 18'sd4;
            4'd14:   atan_lut = 18'sd2;
            default: atan_lut = 18'sd1;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic signed [18:0] x_q, x_d;
    logic signed [18:0] y_q, y_d;
    logic signed [17:0] z_q, z_d;
    logic        [3:0]  i_q, i_d;
    logic        [17:0] mag_q, mag_d;
    logic signed [17:0] angle_q, angle_d;

    logic signed [18:0] x_ext, y_ext;
    logic signed [18:0] x_sh, y_sh;

    // Widen before any negation so that -(-65536) is representable.
    assign x_ext = {{2{vec.x_i[16]}}, vec.x_i};
    assign y_ext = {{2{vec.y_i[16]}}, vec.y_i};
    assign x_sh  = x_q >>> i_q;
    assign y_sh  = y_q >>> i_q;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [33:0] x_wide;
    logic signed [33:0] gain_prod;
    logic signed [18:0] x_comp;

    // 19898 = 2^14 + 2^11 + 2^10 + 2^8 + 2^7 + 2^5 + 2^4 + 2^3 + 2^1, i.e. 1/K in Q15.
    assign x_wide    = {{15{x_q[18]}}, x_q};
    assign gain_prod = (x_wide <<< 14) + (x_wide <<< 11) + (x_wide <<< 10)
                     + (x_wide <<< 8)  + (x_wide <<< 7)  + (x_wide <<< 5)
                     + (x_wide <<< 4)  + (x_wide <<< 3)  + (x_wide <<< 1);
    assign x_comp    = 19'(gain_prod >>> 15);
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        mag_d   = mag_q;
        angle_d = angle_q;

        case (state_q)
            IDLE: begin
                if (vec.valid_i) begin
                    if (x_ext[18] && !y_ext[18]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = Z_HALF_PI;
                    end else if (x_ext[18] && y_ext[18]) begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -Z_HALF_PI;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    i_d     = '0;
                    state_d = ITER;
                end
            end

            ITER: begin
                // Rotate toward the x axis; the sign of y picks the direction.
                if (!y_q[18]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(i_q);
                end
                i_d = i_q + 4'd1;
                if (i_q == 4'd15) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = DONE;
`endif
                end
            end

`ifdef CORDIC_VEC_GAIN_COMP_EN
            COMP: begin
                x_d     = x_comp;
                state_d = DONE;
            end
`endif

            DONE: begin
                if (vec.ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Result registers only change on entry to DONE, so they hold under backpressure.
        if (state_d == DONE && state_q != DONE) begin
            mag_d   = x_d[17:0];
            angle_d = z_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            mag_q   <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
        end
    end

    assign vec.ready_o = (state_q == IDLE);
    assign vec.valid_o = (state_q == DONE);
    assign vec.mag_o   = mag_q;
    assign vec.angle_o = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed corner vectors, random vectors against
// a floating-point atan2/hypot model, backpressure, ignored valid_i and mid-operation reset.
`timescale 1ns/1ps

module tb_cordic_vectoring;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT  = 17;
    localparam real GAIN = 1.0;
`else
    localparam int  LAT  = 16;
    localparam real GAIN = 1.6467602581;
`endif
    localparam real SCALE = 32768.0;
    localparam real PI    = 3.14159265358979;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    int   n_vec    = 0;
    int   n_miss   = 0;

    cordic_vectoring_if vec();

    cordic_vectoring dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .vec      (vec)
    );

    always #5 clk_i = ~clk_i;

    function automatic real model_mag(input int x, input int y);
        return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GAIN;
    endfunction

    function automatic real model_angle(input int x, input int y);
        return $atan2(real'(y), real'(x)) * SCALE;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Angles are compared modulo 2*pi so +pi and -pi results near the cut agree.
    task automatic check_near(input string tag, input int obs, input real exp,
                              input real tol, input bit wrap);
        real d;
        n_vec++;
        d = real'(obs) - exp;
        if (wrap) begin
            if (d > PI * SCALE)       d = d - 2.0 * PI * SCALE;
            else if (d < -PI * SCALE) d = d + 2.0 * PI * SCALE;
        end
        assert (d <= tol && d >= -tol) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0.1f +/- %0.1f", tag, obs, exp, tol);
        end
    endtask

    task automatic apply(input int x, input int y);
        vec.x_i     = x[16:0];
        vec.y_i     = y[16:0];
        vec.valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        vec.valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int cyc = 0;
        while (vec.valid_o !== 1'b1 && cyc < 60) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_cycles);
    endtask

    task automatic release_result(input string tag);
        vec.ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        vec.ready_i = 1'b0;
        check({tag, "_ready_after"}, vec.ready_o, 1);
    endtask

    task automatic run_vec(input string tag, input int x, input int y,
                           input real mtol, input real atol);
        apply(x, y);
        wait_done(tag, LAT);
        check_near({tag, "_mag"}, int'(vec.mag_o), model_mag(x, y), mtol, 1'b0);
        check_near({tag, "_angle"}, int'($signed(vec.angle_o)), model_angle(x, y), atol, 1'b1);
        release_result(tag);
    endtask

    initial begin
        int x, y, m, a;

        vec.valid_i = 1'b0;
        vec.ready_i = 1'b0;
        vec.x_i     = '0;
        vec.y_i     = '0;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", vec.ready_o, 1);
        check("rst_valid", vec.valid_o, 0);
        check("rst_mag", vec.mag_o, 0);
        check("rst_angle", $signed(vec.angle_o), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_vec("x_axis", 32768, 0, 4.0, 2.0);
        run_vec("pos_y", 0, 32768, 24.0, 4.0);
        run_vec("neg_y", 0, -32768, 24.0, 4.0);
        run_vec("neg_x", -32768, 0, 24.0, 6.0);
        run_vec("neg_x_m1", -32768, -1, 24.0, 6.0);
        run_vec("diag", 23170, 23170, 8.0, 4.0);
        run_vec("min_x", -65536, 0, 24.0, 6.0);
        run_vec("min_xy", -65536, -65536, 32.0, 8.0);

        apply(0, 0);
        wait_done("zero", LAT);
        check_near("zero_mag", int'(vec.mag_o), 0.0, 0.0, 1'b0);
        release_result("zero");

        for (int k = 0; k < 12; k++) begin
            do begin
                x = int'($urandom_range(0, 131071)) - 65536;
                y = int'($urandom_range(0, 131071)) - 65536;
            end while (model_mag(x, y) < 16384.0 * GAIN);
            run_vec($sformatf("rand%0d", k), x, y, 24.0, 16.0);
        end

        // valid_i during ITER must be ignored.
        apply(20000, -15000);
        vec.x_i     = 17'sd1000;
        vec.y_i     = 17'sd30000;
        vec.valid_i = 1'b1;
        check("iter_ready_low", vec.ready_o, 0);
        @(posedge clk_i);
        #1;
        vec.valid_i = 1'b0;
        wait_done("bp", LAT - 1);
        check_near("bp_mag", int'(vec.mag_o), model_mag(20000, -15000), 24.0, 1'b0);
        check_near("bp_angle", int'($signed(vec.angle_o)), model_angle(20000, -15000), 16.0, 1'b1);
        m = int'(vec.mag_o);
        a = int'($signed(vec.angle_o));
        for (int k = 0; k < 5; k++) begin
            vec.valid_i = (k == 2);
            check($sformatf("bp_valid_%0d", k), vec.valid_o, 1);
            check($sformatf("bp_ready_%0d", k), vec.ready_o, 0);
            check($sformatf("bp_mag_hold_%0d", k), vec.mag_o, m);
            check($sformatf("bp_angle_hold_%0d", k), $signed(vec.angle_o), a);
            @(posedge clk_i);
            #1;
        end
        vec.valid_i = 1'b0;
        release_result("bp");
        check("bp_valid_drop", vec.valid_o, 0);
        repeat (LAT + 2) @(posedge clk_i);
        #1;
        check("no_ghost_valid", vec.valid_o, 0);
        check("no_ghost_ready", vec.ready_o, 1);

        // Abort a vector mid-iteration with an asynchronous reset.
        apply(-30000, 12345);
        repeat (7) @(posedge clk_i);
        #2;
        reset_ni = 1'b0;
        #1;
        check("abort_valid", vec.valid_o, 0);
        check("abort_ready", vec.ready_o, 1);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("abort_ready_after", vec.ready_o, 1);
        run_vec("post_reset", 32768, 0, 4.0, 2.0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
